// File: rtl/dffe_bank_reader_if.sv
// rtl/dffe_bank_reader_if.sv - control, bank read port and word stream bundle for dffe_bank_reader
interface dffe_bank_reader_if #(
    parameter int ADDR_W = 6
);
    logic              START;
    logic              ABORT;
    logic              BUSY;
    logic              RD_EN;
    logic [ADDR_W-1:0] RD_ADDR;
    logic [7:0]        RD_DATA;
    logic              W_VALID;
    logic              W_READY;
    logic [31:0]       W_DATA;
    logic [3:0]        W_IDX;
    logic              DONE;

    // Reader side: issues bank reads and sources the word stream
    modport master (
        input  START, ABORT, RD_DATA, W_READY,
        output BUSY, RD_EN, RD_ADDR, W_VALID, W_DATA, W_IDX, DONE
    );

    // Environment side: bank plus compression datapath
    modport slave (
        output START, ABORT, RD_DATA, W_READY,
        input  BUSY, RD_EN, RD_ADDR, W_VALID, W_DATA, W_IDX, DONE
    );
endinterface

// File: rtl/dffe_bank_reader.sv
// rtl/dffe_bank_reader.sv - byte-wise bank walker assembling big-endian 32-bit message words
module dffe_bank_reader #(
    parameter int WORDS  = 16,
    parameter int ADDR_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    dffe_bank_reader_if.master    bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LAST  = 3'd2,
        OUT   = 3'd3,
        FIN   = 3'd4
    } state_t;

    localparam logic [3:0] LAST_WORD = 4'(WORDS - 1);

    state_t      state, state_next;
    logic [3:0]  word_idx, word_next;
    logic [1:0]  byte_idx, byte_next;
    logic [31:0] data_q, data_next;
    // Set for the cycle in which the bank returns a byte we asked for
    logic        cap, cap_next;

    // Next-state, counter and shift-register update
    always_comb begin
        state_next = state;
        word_next  = word_idx;
        byte_next  = byte_idx;
        data_next  = data_q;
        cap_next   = 1'b0;
        if (state != IDLE && bus.ABORT) begin
            // Any byte arriving now, or requested now, is dropped
            state_next = IDLE;
            word_next  = 4'd0;
            byte_next  = 2'd0;
            data_next  = 32'd0;
        end else begin
            if (cap) begin
                data_next = {data_q[23:0], bus.RD_DATA};
            end
            case (state)
                IDLE: begin
                    if (bus.START && !bus.ABORT) begin
                        state_next = FETCH;
                        word_next  = 4'd0;
                        byte_next  = 2'd0;
                    end
                end
                FETCH: begin
                    cap_next  = 1'b1;
                    byte_next = byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        state_next = LAST;
                    end
                end
                LAST: begin
                    state_next = OUT;
                end
                OUT: begin
                    if (bus.W_READY) begin
                        if (word_idx == LAST_WORD) begin
                            state_next = FIN;
                        end else begin
                            state_next = FETCH;
                            word_next  = word_idx + 4'd1;
                            byte_next  = 2'd0;
                        end
                    end
                end
                FIN: begin
                    // Leave IDLE with every output, including W_DATA, at zero
                    state_next = IDLE;
                    word_next  = 4'd0;
                    byte_next  = 2'd0;
                    data_next  = 32'd0;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= IDLE;
            word_idx <= 4'd0;
            byte_idx <= 2'd0;
            data_q   <= 32'd0;
            cap      <= 1'b0;
        end else begin
            state    <= state_next;
            word_idx <= word_next;
            byte_idx <= byte_next;
            data_q   <= data_next;
            cap      <= cap_next;
        end
    end

    // Outputs decoded from registered state only
    assign bus.BUSY    = (state != IDLE);
    assign bus.RD_EN   = (state == FETCH);
    assign bus.RD_ADDR = (state == FETCH) ? ADDR_W'({word_idx, byte_idx}) : '0;
    assign bus.W_VALID = (state == OUT);
    assign bus.W_IDX   = (state == OUT) ? word_idx : 4'd0;
    assign bus.W_DATA  = data_q;
    assign bus.DONE    = (state == FIN);
endmodule

// File: doc/dffe_bank_reader.md
# dffe_bank_reader

Read-side sequencer for the 8-bit enable-register banks that hold SHA-256 message bytes. It walks the bank byte by byte over a one-cycle-latency read port and assembles big-endian 32-bit words. Each word is presented to the compression datapath over a valid/ready handshake. It is the consumer counterpart of the byte-write path into the DFFE_PN_8BIT storage.

## Interface
Parameters:
- WORDS, 16, number of 32-bit words per block (1..16)
- ADDR_W, 6, byte address width; must satisfy 2^ADDR_W >= 4*WORDS

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  synchronous active-low reset
- START  in  1  begin reading a block; sampled only in IDLE
- ABORT  in  1  cancel current block; highest priority after reset
- BUSY  out  1  high in every state except IDLE
- RD_EN  out  1  byte read request to bank
- RD_ADDR  out  ADDR_W  byte address {word_idx, byte_idx}
- RD_DATA  in  8  byte returned exactly one cycle after an RD_EN cycle
- W_VALID  out  1  W_DATA/W_IDX hold a complete word
- W_READY  in  1  consumer accepts the word
- W_DATA  out  32  assembled word, first-read byte in [31:24]
- W_IDX  out  4  index of the word on W_DATA
- DONE  out  1  one-cycle pulse after the last word is accepted

Decided: one clock; reset is synchronous and active-low. The ports are CLK and RST_N.

## Operation
- States: IDLE, FETCH, LAST, OUT, FIN.
- IDLE: all outputs 0. START=1 sets word_idx=0 and byte_idx=0, then goes to FETCH.
- FETCH: RD_EN=1 and RD_ADDR={word_idx, byte_idx}. byte_idx increments each cycle. After the cycle that issues byte_idx=3, the state goes to LAST.
- Capture: one cycle after each RD_EN=1 cycle, the shift register updates as W_DATA <= {W_DATA[23:0], RD_DATA}. A capture therefore happens in FETCH cycles 2-4 and in LAST.
- LAST: RD_EN=0. The final byte is captured and the state goes to OUT.
- OUT: W_VALID=1, W_IDX=word_idx. W_DATA and W_IDX stay stable until the handshake.
  - Handshake is W_VALID & W_READY at a rising edge.
  - On handshake with word_idx=WORDS-1: go to FIN.
  - On handshake otherwise: word_idx+1, byte_idx=0, go to FETCH.
  - No handshake: stay in OUT.
- FIN: DONE=1 for exactly one cycle, then IDLE.
- START outside IDLE is ignored.
- A START asserted in the FIN cycle is ignored. START is only honoured once the state has returned to IDLE.
- ABORT=1 in any non-IDLE state:
  - next state is IDLE;
  - RD_EN, W_VALID and DONE are 0 from the next cycle;
  - no DONE pulse;
  - W_DATA is cleared to 0.
- ABORT in IDLE has no effect. ABORT together with START in IDLE stays in IDLE.
- A read issued in the cycle ABORT is sampled is discarded.
- W_READY while W_VALID=0 is ignored.
- Counters: byte_idx is 2 bits and wraps 3->0. word_idx is 4 bits and never exceeds WORDS-1.

## Timing
- Reset, with RST_N low at an edge:
  - state=IDLE, word_idx=0, byte_idx=0;
  - BUSY=0, RD_EN=0, RD_ADDR=0, W_VALID=0, W_DATA=0, W_IDX=0, DONE=0.
  - This holds mid-block as well; the bank needs no clean-up.
- START sampled at edge 0:
  - FETCH during cycles 1-4, with RD_ADDR 0,1,2,3;
  - LAST in cycle 5;
  - W_VALID=1 from cycle 6.
- Minimum period is 6 cycles per word (4 FETCH + LAST + OUT), with W_READY held high.
- With W_READY high throughout, a full 16-word block gives DONE in cycle 16*6+1 = 97 after START.
- BUSY rises the cycle after START and falls the cycle after FIN.
- All outputs are registered or decoded from registered state only. There are no combinational paths from any input to any output.

## Test plan
1. Reset and idle:
   - Stimulus: hold RST_N=0 for 3 cycles, then release with START=0.
   - Response: all outputs 0 and BUSY=0 for 10 cycles.
2. Full block:
   - Stimulus: bank byte n = n; W_READY=1; pulse START.
   - Response: 16 words, W_IDX 0..15, first word 0x00010203 and last word 0x3C3D3E3F.
   - W_VALID high at cycle 6; DONE in cycle 97 and only one cycle wide.
3. Backpressure:
   - Stimulus: W_READY=0 for 5 cycles while word 2 is valid.
   - Response: W_DATA=0x08090A0B and W_IDX=2 held, RD_EN=0 while waiting.
   - Word 3 fetch starts the cycle after the handshake.
4. ABORT mid-FETCH:
   - Stimulus: ABORT during word 5, byte 2.
   - Response: IDLE next cycle, W_DATA=0, no DONE, no W_VALID.
   - A new START restarts at word 0 with first word 0x00010203.
5. Reset mid-OUT:
   - Stimulus: RST_N=0 while W_VALID=1.
   - Response: W_VALID=0 and BUSY=0 the next cycle; the next START restarts at RD_ADDR=0.
6. START ignored and WORDS=1:
   - Stimulus: pulse START during FETCH; separately run a WORDS=1 build.
   - Response: no restart during FETCH.
   - The WORDS=1 build emits a single word followed by a DONE pulse 7 cycles after START.
